// File: rtl/spi_reg_slave.sv
// SPI register slave: R/W bit, address, turnaround, data and tail fields, all on SCLK rise.
// Holds a 2^ADDR_W x DATA_W register file that is read out on MISO or written from MOSI.
module spi_reg_slave #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 16,
   parameter int PRE_DEAD  = 5,
   parameter int POST_DEAD = 5
) (
   input  logic SCLK,
   input  logic rst_n,
   input  logic CSN,
   input  logic MOSI,
   output logic MISO,
   output logic MISO_enable
);

   localparam int FRAME_LEN = 1 + ADDR_W + PRE_DEAD + DATA_W + POST_DEAD;
   localparam int CNT_W     = $clog2(FRAME_LEN + 1);

   // Edge numbers count from 1 at the first SCLK rise after CSN falls; PRE_DEAD must be >= 1.
   localparam logic [CNT_W-1:0] E_CMD        = CNT_W'(1);
   localparam logic [CNT_W-1:0] E_ADDR_LAST  = CNT_W'(1 + ADDR_W);
   localparam logic [CNT_W-1:0] E_LOAD       = CNT_W'(ADDR_W + 2);
   localparam logic [CNT_W-1:0] E_EN_ON      = CNT_W'(ADDR_W + 1 + PRE_DEAD);
   localparam logic [CNT_W-1:0] E_DATA_FIRST = CNT_W'(ADDR_W + PRE_DEAD + 2);
   localparam logic [CNT_W-1:0] E_DATA_LAST  = CNT_W'(ADDR_W + PRE_DEAD + 1 + DATA_W);
   localparam logic [CNT_W-1:0] E_LAST       = CNT_W'(FRAME_LEN);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, TURN, DATA, TAIL, DONE} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                rw_q, rw_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   rd_shift_q, rd_shift_d;
   logic [DATA_W-2:0]   wr_shift_q, wr_shift_d;
   logic                miso_en_q, miso_en_d;
   logic                armed_q, armed_d;
   logic [1:0]          rst_sync_q;
   logic                rst_int_n;
   logic                frame_rst_n;
   logic                mem_we;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_q [2**ADDR_W];

   always_ff @(posedge SCLK or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_int_n   = rst_sync_q[1];
   assign frame_rst_n = rst_int_n & ~CSN;

   // A frame may only begin once CSN has been seen high after reset, so a reset
   // released mid-frame never picks up the tail of that frame.
   always_ff @(posedge SCLK or negedge rst_int_n) begin
      if (!rst_int_n) begin
         armed_q <= 1'b0;
      end else begin
         armed_q <= armed_d;
      end
   end

   always_comb begin
      armed_d    = armed_q | CSN;
      cnt_d      = cnt_q;
      state_d    = state_q;
      rw_d       = rw_q;
      addr_d     = addr_q;
      rd_shift_d = rd_shift_q;
      wr_shift_d = wr_shift_q;
      miso_en_d  = miso_en_q;
      mem_we     = 1'b0;
      mem_wdata  = {wr_shift_q, MOSI};
      if (armed_q && state_q != DONE) begin
         if (cnt_q == E_LAST) begin
            state_d = DONE;
         end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == E_CMD) begin
               state_d = CMD;
               rw_d    = MOSI;
            end else if (cnt_d <= E_ADDR_LAST) begin
               state_d = ADDR;
               addr_d  = {addr_q[ADDR_W-2:0], MOSI};
            end else if (cnt_d < E_DATA_FIRST) begin
               state_d = TURN;
               if (cnt_d == E_LOAD) rd_shift_d = mem_q[addr_q];
               if (cnt_d == E_EN_ON) miso_en_d = ~rw_q;
            end else if (cnt_d <= E_DATA_LAST) begin
               state_d    = DATA;
               wr_shift_d = {wr_shift_q[DATA_W-3:0], MOSI};
               if (cnt_d == E_DATA_LAST) begin
                  miso_en_d = 1'b0;
                  mem_we    = rw_q;
               end else begin
                  rd_shift_d = {rd_shift_q[DATA_W-2:0], 1'b0};
               end
            end else begin
               state_d = TAIL;
            end
         end
      end
   end

   always_ff @(posedge SCLK or negedge frame_rst_n) begin
      if (!frame_rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rw_q       <= 1'b0;
         addr_q     <= '0;
         rd_shift_q <= '0;
         wr_shift_q <= '0;
         miso_en_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rw_q       <= rw_d;
         addr_q     <= addr_d;
         rd_shift_q <= rd_shift_d;
         wr_shift_q <= wr_shift_d;
         miso_en_q  <= miso_en_d;
      end
   end

   // Register contents survive CSN aborts; only reset clears them.
   always_ff @(posedge SCLK or negedge rst_int_n) begin
      if (!rst_int_n) begin
         for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= '0;
      end else if (mem_we) begin
         mem_q[addr_q] <= mem_wdata;
      end
   end

   assign MISO_enable = miso_en_q;
   assign MISO        = miso_en_q & rd_shift_q[DATA_W-1];

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: frames driven bit by bit, read data checked through a scoreboard queue.
module tb_spi_reg_slave;

   logic SCLK;
   logic rst_n;
   logic CSN;
   logic MOSI;
   logic MISO;
   logic MISO_enable;

   int checks;
   int passed;

   logic [15:0] model_mem [256];
   logic [15:0] exp_q [$];
   logic [15:0] sweep_val [256];

   spi_reg_slave #(
      .ADDR_W   (8),
      .DATA_W   (16),
      .PRE_DEAD (5),
      .POST_DEAD(5)
   ) dut (
      .SCLK       (SCLK),
      .rst_n      (rst_n),
      .CSN        (CSN),
      .MOSI       (MOSI),
      .MISO       (MISO),
      .MISO_enable(MISO_enable)
   );

   initial begin
      SCLK = 1'b0;
      forever #5 SCLK = ~SCLK;
   end

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passed);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) passed++;
      else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
   endtask

   // One frame of n_edges rising edges; n_edges < 30 aborts, rst_at > 0 pulses rst_n after that edge.
   task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [15:0] data,
                                input int n_edges, input int rst_at, input string tag);
      logic [63:0] obs_en, obs_miso, exp_en, exp_miso;
      logic [15:0] frame_data, got, want;
      bit complete;
      obs_en     = '0;
      obs_miso   = '0;
      exp_en     = '0;
      exp_miso   = '0;
      got        = '0;
      complete   = (n_edges >= 30) && (rst_at == 0);
      frame_data = wr ? data : model_mem[addr];
      if (!wr && complete) exp_q.push_back(model_mem[addr]);
      for (int k = 1; k <= n_edges; k++) begin
         if (!wr && k >= 15 && k <= 30 && (rst_at == 0 || k <= rst_at)) begin
            exp_en[k]   = 1'b1;
            exp_miso[k] = frame_data[30-k];
         end
      end

      @(negedge SCLK);
      CSN = 1'b0;
      for (int k = 1; k <= n_edges; k++) begin
         if (k == 1)                 MOSI = wr;
         else if (k <= 9)            MOSI = addr[9-k];
         else if (k >= 15 && k <= 30) MOSI = data[30-k];
         else                        MOSI = 1'($urandom_range(0, 1));
         obs_en[k]   = MISO_enable;
         obs_miso[k] = MISO;
         if (k >= 15 && k <= 30) got[30-k] = MISO;
         @(posedge SCLK);
         @(negedge SCLK);
         if (k == rst_at) begin
            rst_n = 1'b0;
            #1;
            checkOutput({tag, "_in_reset"}, {62'd0, MISO_enable, MISO}, 64'd0);
            #1;
            rst_n = 1'b1;
            for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
         end
      end
      CSN = 1'b1;
      #1;
      checkOutput({tag, "_csn_high"}, {62'd0, MISO_enable, MISO}, 64'd0);
      checkOutput({tag, "_enable"}, obs_en, exp_en);
      checkOutput({tag, "_miso"}, obs_miso, exp_miso);
      if (!wr && complete) begin
         if (exp_q.size() == 0) begin
            checkOutput({tag, "_queue"}, 64'd0, 64'd1);
         end else begin
            want = exp_q.pop_front();
            checkOutput({tag, "_data"}, {48'd0, got}, {48'd0, want});
         end
      end
      if (wr && complete) model_mem[addr] = data;
      repeat (3) @(negedge SCLK);
   endtask

   initial begin
      checks = 0;
      passed = 0;
      rst_n  = 1'b0;
      CSN    = 1'b1;
      MOSI   = 1'b0;
      for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;

      repeat (3) @(negedge SCLK);
      checkOutput("reset_outputs", {62'd0, MISO_enable, MISO}, 64'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge SCLK);
      $display("[TB] reset released");

      applyStimulus(1'b0, 8'h7F, 16'h0000, 35, 0, "read_7f_default");
      applyStimulus(1'b1, 8'h12, 16'hA5C3, 35, 0, "write_12");
      applyStimulus(1'b0, 8'h12, 16'h0000, 35, 0, "read_12");

      applyStimulus(1'b1, 8'h40, 16'h0BEE, 35, 0, "write_40");
      applyStimulus(1'b1, 8'h40, 16'hFFFF, 20, 0, "abort_write_40");
      applyStimulus(1'b0, 8'h40, 16'h0000, 35, 0, "read_40");
      applyStimulus(1'b0, 8'h12, 16'h0000, 20, 0, "abort_read_12");
      applyStimulus(1'b0, 8'h12, 16'h0000, 35, 0, "reread_12");

      applyStimulus(1'b1, 8'h03, 16'h1234, 40, 0, "long_write_03");
      applyStimulus(1'b0, 8'h03, 16'h0000, 35, 0, "read_03");

      $display("[TB] full sweep");
      for (int a = 0; a < 256; a++) begin
         sweep_val[a] = 16'($urandom);
         applyStimulus(1'b1, 8'(a), sweep_val[a], 35, 0, "sweep_write");
      end
      for (int a = 0; a < 256; a++) begin
         applyStimulus(1'b0, 8'(a), 16'h0000, 35, 0, "sweep_read");
      end

      $display("[TB] reset mid-frame");
      applyStimulus(1'b1, 8'h05, 16'hBEEF, 35, 18, "reset_write_05");
      applyStimulus(1'b0, 8'h05, 16'h0000, 35, 0, "read_05");
      applyStimulus(1'b0, 8'hFF, 16'h0000, 35, 0, "read_ff");
      applyStimulus(1'b1, 8'hFF, 16'h5A5A, 35, 0, "write_ff");
      applyStimulus(1'b0, 8'hFF, 16'h0000, 35, 0, "reread_ff");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/spi_reg_slave.md
SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning address field width and register count 2^ADDR_W.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning register and data field width.
REQ-003 The block SHALL have parameter PRE_DEAD, default 5, meaning number of turnaround edges between address and data.
REQ-004 The block SHALL have parameter POST_DEAD, default 5, meaning number of trailing edges after data.
REQ-005 The block SHALL have port SCLK, input, 1 bit: the single clock; all sequential logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port CSN, input, 1 bit: active-low chip select; high asynchronously aborts the frame.
REQ-008 The block SHALL have port MOSI, input, 1 bit: serial data from the master, sampled on SCLK rise.
REQ-009 The block SHALL have port MISO, output, 1 bit: serial read data, MSB first.
REQ-010 The block SHALL have port MISO_enable, output, 1 bit: high while MISO carries valid read data.

Function
REQ-011 The frame SHALL be 1 R/W bit (1=write, 0=read), then ADDR_W address bits MSB first, then PRE_DEAD don't-care bits, then DATA_W data bits MSB first, then POST_DEAD don't-care bits. The default frame is 35 rising edges.
REQ-012 A frame edge counter SHALL count SCLK rises while CSN=0, from 1 at the first rise after CSN falls. It SHALL saturate at the frame length; further edges SHALL be ignored until CSN rises.
REQ-013 FSM states SHALL be IDLE -> CMD (edge 1) -> ADDR (edges 2..9) -> TURN (10..14) -> DATA (15..30) -> TAIL (31..35) -> DONE, with DONE held until CSN=1.
REQ-014 CSN=1 SHALL asynchronously force IDLE and clear the counter, shift registers and MISO_enable. It SHALL NOT alter register contents.
REQ-015 The storage SHALL be 2^ADDR_W x DATA_W registers.
REQ-016 Read preparation: on edge 10, the read shift register SHALL load mem[addr] using the complete 8-bit address.
REQ-017 Read enable: for read frames, MISO_enable SHALL go high on edge 14 and low on edge 30.
REQ-018 Read shifting: the read shift register SHALL shift left on edges 15..29, so that MISO is stable before each of edges 15..30. The master samples bit 15 at edge 15 and bit 0 at edge 30.
REQ-019 MISO SHALL equal read_shift[DATA_W-1] when MISO_enable=1 and 0 otherwise; MISO is never undriven.
REQ-020 Write frames: the write shift register SHALL capture MOSI on edges 15..30. On edge 30, mem[addr] SHALL be written with {shift[DATA_W-2:0], MOSI}.
REQ-021 Write frames SHALL keep MISO_enable=0 throughout.
REQ-022 A frame aborted by CSN before edge 30 SHALL leave mem unchanged, and MISO_enable SHALL drop immediately.
REQ-023 Read frames SHALL never modify mem.
REQ-024 Address 0xFF SHALL behave like any other address; there is no wrap or alias.
REQ-025 A read of an address SHALL return the value from the most recent completed write, including a write in the immediately preceding frame.

Reset
REQ-026 On rst_n=0 the block SHALL asynchronously force state IDLE, counter 0, all shift registers 0, all 256 registers 0x0000, MISO=0 and MISO_enable=0.
REQ-027 Reset asserted mid-frame SHALL discard the frame without writing. After rst_n=1, the first frame SHALL start only after CSN has been seen high.
REQ-028 The rst_n release SHALL be synchronised to SCLK so that the first post-reset edge is handled cleanly.

Verification
REQ-029 Write/read back: write 0xA5C3 to addr 0x12, then read addr 0x12 -> 0xA5C3 sampled at edges 15..30, MISO_enable high exactly for those samples.
REQ-030 Full sweep: write a random value to each of addr 0..255, then read all 256 -> zero mismatches, including addr 0x00 and 0xFF.
REQ-031 Reset defaults: after reset, read addr 0x7F -> 0x0000; a write frame -> MISO_enable=0 on all 35 edges and MISO=0.
REQ-032 Abort: write 0xFFFF to addr 0x40 with CSN raised after edge 20, then read 0x40 -> prior value unchanged, MISO_enable=0 immediately after CSN rose.
REQ-033 Over-long frame: 40 SCLK edges in one write of 0x1234 to addr 0x03 -> mem[0x03]=0x1234, extra edges ignored, next frame correct.
REQ-034 Reset mid-frame: pulse rst_n low at edge 18 of a write to addr 0x05 -> mem[0x05]=0x0000, and a subsequent read frame is correct.
